cv32e40p_wfi_ctrl: RTL

WFI sequencing and wake-detection stage that sits directly upstream of the core sleep unit. It receives a WFI request from the controller and drains outstanding fetch and LSU activity. It then drops `ctrl_busy_o` so the sleep unit can gate the core clock, and raises `wake_from_sleep_o` in the same cycle a wake source appears. It runs on the free-running clock so that it can observe wake sources while the core clock is gated.

---
 rtl/cv32e40p_pkg.sv | 11 +
 rtl/cv32e40p_sat_counter.sv | 38 +++
 rtl/cv32e40p_wfi_ctrl_sva.sv | 24 ++
 rtl/cv32e40p_wfi_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types for the WFI sequencing stage.
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    WFI_RUN   = 2'd0,
    WFI_DRAIN = 2'd1,
    WFI_SLEEP = 2'd2,
    WFI_WAKE  = 2'd3
  } wfi_state_e;

endpackage

// File: rtl/cv32e40p_sat_counter.sv
// Saturating up-counter with a clear that wins over increment.
module cv32e40p_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // next count: clear first, then increment unless already all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {WIDTH{1'b0}};
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40p_wfi_ctrl_sva.sv
// Protocol checks for the WFI sequencing stage.
`ifdef CV32E40P_ASSERT_ON
module cv32e40p_wfi_ctrl_sva
  import cv32e40p_pkg::*;
(
  input logic       clk_i,
  input logic       rst_ni,
  input logic       wfi_req_i,
  input wfi_state_e state_i,
  input logic       ctrl_busy_i,
  input logic       wfi_done_i
);

  a_wfi_only_in_run: assert property (@(posedge clk_i) disable iff (!rst_ni)
    wfi_req_i |-> (state_i == WFI_RUN));

  a_done_single_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
    wfi_done_i |=> !wfi_done_i);

  a_idle_only_in_sleep: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !ctrl_busy_i |-> (state_i == WFI_SLEEP));

endmodule
`endif

// File: rtl/cv32e40p_wfi_ctrl.sv
// WFI sequencing: drain fetch/LSU, signal idle to the sleep unit, detect wake
// sources on the free-running clock and hand control back to the controller.
module cv32e40p_wfi_ctrl
  import cv32e40p_pkg::*;
#(
  parameter int unsigned IRQ_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk_ungated_i,
  input  logic                 rst_n,
  input  logic                 wfi_req_i,
  input  logic                 debug_wfi_no_sleep_i,
  input  logic                 if_busy_i,
  input  logic                 lsu_busy_i,
  input  logic [IRQ_WIDTH-1:0] irq_pending_i,
  input  logic [IRQ_WIDTH-1:0] irq_enable_i,
  input  logic                 debug_req_i,
  input  logic                 cnt_clear_i,
  output logic                 ctrl_busy_o,
  output logic                 wake_from_sleep_o,
  output logic                 wfi_done_o,
  output logic [CNT_WIDTH-1:0] sleep_cycles_o
);

  wfi_state_e state_q;
  wfi_state_e state_d;
  logic       wake_s;
  logic       in_sleep_s;

  // mstatus.MIE is intentionally ignored: WFI wakes on any enabled pending irq
  assign wake_s     = (|(irq_pending_i & irq_enable_i)) | debug_req_i;
  assign in_sleep_s = (state_q == WFI_SLEEP);

  // next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      WFI_RUN: begin
        if (wfi_req_i) begin
          state_d = (debug_wfi_no_sleep_i || wake_s) ? WFI_WAKE : WFI_DRAIN;
        end else begin
          state_d = WFI_RUN;
        end
      end
      WFI_DRAIN: begin
        if (wake_s) begin
          state_d = WFI_WAKE;
        end else if (!if_busy_i && !lsu_busy_i) begin
          state_d = WFI_SLEEP;
        end else begin
          state_d = WFI_DRAIN;
        end
      end
      WFI_SLEEP: begin
        if (wake_s) begin
          state_d = WFI_WAKE;
        end else begin
          state_d = WFI_SLEEP;
        end
      end
      WFI_WAKE: begin
        state_d = WFI_RUN;
      end
      default: begin
        state_d = WFI_RUN;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WFI_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // wake_from_sleep_o is the only output with a combinational input path
  assign ctrl_busy_o       = !in_sleep_s;
  assign wfi_done_o        = (state_q == WFI_WAKE);
  assign wake_from_sleep_o = in_sleep_s & wake_s;

  cv32e40p_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) i_sleep_cnt (
    .clk_i  (clk_ungated_i),
    .rst_ni (rst_n),
    .inc_i  (in_sleep_s),
    .clr_i  (cnt_clear_i),
    .cnt_o  (sleep_cycles_o)
  );

`ifdef CV32E40P_ASSERT_ON
  cv32e40p_wfi_ctrl_sva i_sva (
    .clk_i       (clk_ungated_i),
    .rst_ni      (rst_n),
    .wfi_req_i   (wfi_req_i),
    .state_i     (state_q),
    .ctrl_busy_i (ctrl_busy_o),
    .wfi_done_i  (wfi_done_o)
  );
`endif

endmodule
